ahb_sram_slave: RTL and testbench

- Shrinked-AHB 8-bit SRAM slave; sits directly downstream of the core's bus unit and answers the master's haddr/hwrite/hburst/htrans/hwdata with hrdata/hready/hresp.
- Serves L1 line refills (bursts) and single read/write-through accesses.
- Programmable wait states, burst fast-path, error response for out-of-range addresses.

---
 rtl/ahb_sram_slave.sv | 213 +++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: reduced-AHB 8-bit SRAM slave with programmable wait states.
// Non-sequential beats insert WAIT_CYCLES wait states, and sequential burst
// beats insert BURST_WAIT wait states. An address outside the SRAM window
// gets a two-cycle error response.
// Optional feature: define AHB_SRAM_WPROT_EN to turn writes at or above
// WP_BASE (inside the SRAM window) into error responses.
module ahb_sram_slave #(
  parameter int                  BUS_ADDR    = 24,
  parameter int                  MEM_AW      = 16,
  parameter int                  WAIT_CYCLES = 1,
  parameter int                  BURST_WAIT  = 0,
  parameter logic [BUS_ADDR-1:0] WP_BASE     = 24'h00F000
) (
  input  logic                clk,
  input  logic                hreset_n,
  input  logic                hsel,
  input  logic [BUS_ADDR-1:0] haddr,
  input  logic                hwrite,
  input  logic                htrans,
  input  logic                hburst,
  input  logic [7:0]          hwdata,
  output logic                hready,
  output logic                hresp,
  output logic [7:0]          hrdata
);

`ifdef AHB_SRAM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte array backing the slave. It is never cleared by reset.
  logic [7:0]          mem_q [0:DEPTH-1];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [BUS_ADDR-1:0] prev_addr_q, prev_addr_d;
  logic                prev_burst_q, prev_burst_d;
  logic                hready_q, hready_d;
  logic                hresp_q, hresp_d;
  logic [7:0]          hrdata_q, hrdata_d;

  logic                accept_s;
  logic                oor_s;
  logic                wp_err_s;
  logic                err_s;
  logic                seq_s;
  logic [BUS_ADDR-1:0] prev_addr_inc_s;
  logic [3:0]          wsel_s;

  // Decode the address phase: acceptance, range check, protection, sequential beats.
  always_comb begin
    accept_s        = hsel & htrans & hready_q;
    oor_s           = |haddr[BUS_ADDR-1:MEM_AW];
    wp_err_s        = WPROT_ON & hwrite & ~oor_s & (haddr >= WP_BASE);
    err_s           = oor_s | wp_err_s;
    prev_addr_inc_s = prev_addr_q + BUS_ADDR'(1);
    seq_s           = hburst & prev_burst_q & (haddr == prev_addr_inc_s);
    if (seq_s) begin
      wsel_s = 4'(BURST_WAIT);
    end else begin
      wsel_s = 4'(WAIT_CYCLES);
    end
  end

  // Track the last accepted beat. Any idle address phase breaks the burst chain.
  always_comb begin
    prev_addr_d  = prev_addr_q;
    prev_burst_d = prev_burst_q;
    if (accept_s) begin
      prev_addr_d  = haddr;
      prev_burst_d = hburst;
    end else if (hready_q) begin
      prev_addr_d  = {BUS_ADDR{1'b0}};
      prev_burst_d = 1'b0;
    end else begin
      prev_addr_d  = prev_addr_q;
      prev_burst_d = prev_burst_q;
    end
  end

  // Compute the next FSM state. The wait counter and the beat latches follow it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          addr_d  = haddr[MEM_AW-1:0];
          write_d = hwrite;
          if (err_s) begin
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
          end else if (wsel_s == 4'd0) begin
            state_d = ST_DATA;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wsel_s;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Derive the bus outputs from the next state so that they leave the slave registered.
  always_comb begin
    hready_d = 1'b1;
    hresp_d  = 1'b0;
    hrdata_d = hrdata_q;
    case (state_d)
      ST_WAIT: begin
        hready_d = 1'b0;
        hresp_d  = 1'b0;
      end
      ST_ERR1: begin
        hready_d = 1'b0;
        hresp_d  = 1'b1;
      end
      ST_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
      end
    endcase
    // Load read data on entry to DATA. A write that is still in DATA to the same byte
    // has not reached the array yet, so forward its data instead.
    if ((state_d == ST_DATA) && !write_d) begin
      if ((state_q == ST_DATA) && write_q && (addr_q == addr_d)) begin
        hrdata_d = hwdata;
      end else begin
        hrdata_d = mem_q[addr_d];
      end
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // Update the state register, the beat latches and the registered outputs.
  always_ff @(posedge clk) begin
    if (!hreset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= {MEM_AW{1'b0}};
      write_q      <= 1'b0;
      prev_addr_q  <= {BUS_ADDR{1'b0}};
      prev_burst_q <= 1'b0;
      hready_q     <= 1'b1;
      hresp_q      <= 1'b0;
      hrdata_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      prev_addr_q  <= prev_addr_d;
      prev_burst_q <= prev_burst_d;
      hready_q     <= hready_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
    end
  end

  // Commit a write on the edge that ends its DATA cycle. Reset drops the write.
  always_ff @(posedge clk) begin
    if (hreset_n && (state_q == ST_DATA) && write_q) begin
      mem_q[addr_q] <= hwdata;
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave (WAIT_CYCLES=2, BURST_WAIT=0).
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic [23:0] haddr;
  logic        hwrite;
  logic        htrans;
  logic        hburst;
  logic [7:0]  hwdata;
  logic        hready;
  logic        hresp;
  logic [7:0]  hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  int          w;
  logic [7:0]  rd;
  logic        rs;
  logic [7:0]  old_v;

  always #5 clk = ~clk;

  ahb_sram_slave #(
    .BUS_ADDR(24), .MEM_AW(16), .WAIT_CYCLES(2), .BURST_WAIT(0), .WP_BASE(24'h00F000)
  ) dut (
    .clk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i * 37 + 11;
    return v[7:0];
  endfunction

  // The task expects hready=1 when it is called. It drives one address phase and
  // counts the wait cycles. It returns at the negedge of the final data cycle, so
  // the caller can pipeline the next beat from there.
  task automatic xfer(input logic [23:0] a, input logic wr, input logic b, input logic [7:0] wd,
                      output int waits, output logic [7:0] rdo, output logic rso);
    haddr = a; hwrite = wr; hburst = b; htrans = 1'b1; hsel = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hburst = 1'b0; hwdata = wd;
    waits = 0;
    @(negedge clk);
    while (!hready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rdo = hrdata;
    rso = hresp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset_n = 1'b0; hsel = 1'b0; htrans = 1'b0; hwrite = 1'b0;
    hburst = 1'b0; haddr = 24'h0; hwdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hready", hready, 1'b1);
    check("reset_hresp", hresp, 1'b0);
    check("reset_hrdata", hrdata, 8'h00);
    hreset_n = 1'b1;

    // Preload two bytes, then reset again. Reset does not clear the array.
    xfer(24'h000010, 1'b1, 1'b0, 8'hA5, w, rd, rs);
    check("preload_wait", w, 2);
    xfer(24'h000050, 1'b1, 1'b0, 8'h12, w, rd, rs);
    @(posedge clk); #1;
    hreset_n = 1'b0;
    @(posedge clk); #1;
    hreset_n = 1'b1;

    // Single read after reset.
    xfer(24'h000010, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("rd10_wait", w, 2);
    check("rd10_data", rd, 8'hA5);
    check("rd10_resp", rs, 1'b0);

    // Write followed back-to-back by a read of the same byte. hrdata holds during the write.
    xfer(24'h000123, 1'b1, 1'b0, 8'h3C, w, rd, rs);
    check("wr123_wait", w, 2);
    check("wr123_hold", rd, 8'hA5);
    check("wr123_resp", rs, 1'b0);
    xfer(24'h000123, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("rd123_data", rd, 8'h3C);
    check("rd123_resp", rs, 1'b0);

    // 16-beat write burst, then 16-beat read burst.
    for (int i = 0; i < 16; i++) begin
      xfer(24'h000200 + 24'(i), 1'b1, 1'b1, pat(i), w, rd, rs);
      check($sformatf("wburst_wait[%0d]", i), w, (i == 0) ? 2 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(24'h000200 + 24'(i), 1'b0, 1'b1, 8'h00, w, rd, rs);
      check($sformatf("rburst_wait[%0d]", i), w, (i == 0) ? 2 : 0);
      check($sformatf("rburst_data[%0d]", i), rd, pat(i));
      check($sformatf("rburst_resp[%0d]", i), rs, 1'b0);
    end

    // Sequential-detection boundaries. Each beat writes, so no read of an unwritten byte occurs.
    xfer(24'h000300, 1'b1, 1'b1, 8'h01, w, rd, rs);
    check("seq_jump_in", w, 2);
    xfer(24'h000302, 1'b1, 1'b1, 8'h02, w, rd, rs);
    check("seq_gap", w, 2);
    xfer(24'h000303, 1'b1, 1'b1, 8'h03, w, rd, rs);
    check("seq_ok", w, 0);
    @(posedge clk); #1;
    xfer(24'h000304, 1'b1, 1'b1, 8'h04, w, rd, rs);
    check("seq_after_idle", w, 2);
    xfer(24'h000305, 1'b1, 1'b0, 8'h05, w, rd, rs);
    xfer(24'h000306, 1'b1, 1'b1, 8'h06, w, rd, rs);
    check("seq_prev_single", w, 2);

    // Out-of-range read. A transfer presented during ERR1 must be ignored.
    @(posedge clk); #1;
    haddr = 24'h010000; hwrite = 1'b0; htrans = 1'b1; hsel = 1'b1;
    @(posedge clk); #1;
    haddr = 24'h000010; htrans = 1'b1;
    @(negedge clk);
    check("err1_hready", hready, 1'b0);
    check("err1_hresp", hresp, 1'b1);
    @(posedge clk); #1;
    htrans = 1'b0;
    @(negedge clk);
    check("err2_hready", hready, 1'b1);
    check("err2_hresp", hresp, 1'b1);
    @(negedge clk);
    check("err_idle_hready", hready, 1'b1);
    check("err_idle_hresp", hresp, 1'b0);

    // An out-of-range write must not alias into the array.
    xfer(24'h010010, 1'b1, 1'b0, 8'hEE, w, rd, rs);
    check("oor_wr_wait", w, 1);
    check("oor_wr_resp", rs, 1'b1);
    xfer(24'h000010, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("oor_mem_kept", rd, 8'hA5);
    check("oor_after_resp", rs, 1'b0);

    // Reset during the second wait cycle of a write.
    @(posedge clk); #1;
    haddr = 24'h000050; hwrite = 1'b1; htrans = 1'b1; hsel = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hwdata = 8'h77;
    @(negedge clk);
    check("midwait_hready", hready, 1'b0);
    @(posedge clk); #1;
    hreset_n = 1'b0;
    @(negedge clk);
    check("midwait2_hready", hready, 1'b0);
    @(posedge clk); #1;
    hreset_n = 1'b1;
    @(negedge clk);
    check("rstmid_hready", hready, 1'b1);
    check("rstmid_hresp", hresp, 1'b0);
    check("rstmid_hrdata", hrdata, 8'h00);
    xfer(24'h000050, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("rstmid_mem", rd, 8'h12);

    // Write to the first protected byte.
`ifdef AHB_SRAM_WPROT_EN
    xfer(24'h00F000, 1'b0, 1'b0, 8'h00, w, rd, rs);
    old_v = rd;
    xfer(24'h00F000, 1'b1, 1'b0, 8'h11, w, rd, rs);
    check("wp_wr_wait", w, 1);
    check("wp_wr_resp", rs, 1'b1);
    xfer(24'h00F000, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("wp_rd_resp", rs, 1'b0);
    check("wp_rd_data", rd, old_v);
`else
    old_v = 8'h11;
    xfer(24'h00F000, 1'b1, 1'b0, old_v, w, rd, rs);
    check("wp_wr_wait", w, 2);
    check("wp_wr_resp", rs, 1'b0);
    xfer(24'h00F000, 1'b0, 1'b0, 8'h00, w, rd, rs);
    check("wp_rd_resp", rs, 1'b0);
    check("wp_rd_data", rd, 8'h11);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
